ecc_pmul_responder: RTL
=======================

ECC_PMUL_RESPONDER -- requirements
Module: ecc_pmul_responder

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL: estart  in  1  level request from the ECC/3DES controller; held high until edone is seen.
REQ-004 SHALL: k  in  163  scalar, sampled only in LOAD.
REQ-005 SHALL: Px, Py  in  164 each  base point, sampled only in LOAD.
REQ-006 SHALL: op_valid  out  1  GF point-op request valid.
REQ-007 SHALL: op_code  out  1  0=DOUBLE(A), 1=ADD(A,B).
REQ-008 SHALL: op_ax, op_ay, op_bx, op_by  out  164 each  operand A = accumulator, operand B = latched base point.
REQ-009 SHALL: op_ready  in  1  request accepted when op_valid and op_ready are both high on a rising edge.
REQ-010 SHALL: res_valid, res_x, res_y  in  1/164/164  one-cycle result strobe from the GF unit.
REQ-011 SHALL: Pox, Poy  out  164 each  result point; Pinf  out  1  result is point at infinity.
REQ-012 SHALL: edone  out  1  one-cycle completion pulse; busy  out  1  high in every state except IDLE.

Function
REQ-013 SHALL: states are IDLE, LOAD, STEP, DBL_REQ, DBL_WAIT, ADD_CHK, ADD_REQ, ADD_WAIT, DONE, HOLD.
REQ-014 SHALL: IDLE->LOAD when estart=1; LOAD latches k/Px/Py, sets idx=162 and acc_inf=1, then ->STEP.
REQ-015 SHALL: STEP: acc_inf=1 ->ADD_CHK (doubling infinity skipped, no op); acc_inf=0 ->DBL_REQ.
REQ-016 SHALL: DBL_REQ/ADD_REQ: op_valid=1 with stable op_code and operands until accepted, then ->DBL_WAIT/ADD_WAIT.
REQ-017 SHALL: *_WAIT: on res_valid=1, acc<=res_x/res_y. DBL_WAIT then ->ADD_CHK; ADD_WAIT then ->NEXT behaviour, identical to ADD_CHK's exit in REQ-018.
REQ-018 SHALL: ADD_CHK: if k[idx]=0, no op. If k[idx]=1 and acc_inf=1, acc<=P and acc_inf<=0 with no op. If k[idx]=1 and acc_inf=0, ->ADD_REQ. On exit with no op: idx=0 ->DONE, else idx-1 ->STEP.
REQ-019 SHALL: res_valid is ignored outside *_WAIT; op_ready is ignored outside *_REQ.
REQ-020 SHALL: DONE: Pox/Poy<=acc (zeros if acc_inf=1), Pinf<=acc_inf; edone=1 for exactly one cycle, coincident with the registered Pox/Poy/Pinf already valid, then ->HOLD.
REQ-021 SHALL: HOLD ->IDLE when estart=0; estart still high in HOLD does not restart.
REQ-022 SHALL: Pox/Poy/Pinf hold their value from DONE until the next DONE or reset.
REQ-023 SHALL: op-free iteration costs exactly 2 cycles per bit (STEP+ADD_CHK); k=0 gives edone 328 cycles after the IDLE cycle sampling estart=1.

Reset
REQ-024 SHALL: rst=1 at a rising edge forces IDLE and zeroes op_valid, op_code, all operand outputs, Pox, Poy, Pinf, edone, busy, idx, acc, and sets acc_inf=1; this applies in any state, including mid-operation.
REQ-025 SHALL: a result strobe arriving after a mid-operation reset is ignored.

Configuration
REQ-026 SHALL: the macro ECC_ABORT_EN compiles in abort. When defined, estart=0 in STEP, ADD_CHK, DBL_REQ or ADD_REQ returns the block to IDLE on the next edge. In DBL_WAIT or ADD_WAIT, the block returns to IDLE after res_valid and discards the result. No edone is issued and Pox/Poy/Pinf are unchanged.
REQ-027 SHALL: when ECC_ABORT_EN is undefined, estart is ignored from LOAD through DONE.

Verification
REQ-028 SHALL: k=0, estart held high -> zero op_valid pulses; edone at cycle 328; Pox=Poy=0, Pinf=1.
REQ-029 SHALL: k=1, P=(0x5,0x7) -> no ops; edone at cycle 328; Pox=0x5, Poy=0x7, Pinf=0.
REQ-030 SHALL: k=3, GF model with op_ready delay 2 and result delay 5 -> exactly one DOUBLE then one ADD issued; operands held stable while op_ready=0; Pox/Poy equal the model's ADD result.
REQ-031 SHALL: spurious res_valid while in DBL_REQ, plus estart kept high 10 cycles after edone -> spurious strobe ignored, no restart, edone a single pulse.
REQ-032 SHALL: rst pulsed during ADD_WAIT for k=0x7 -> IDLE next cycle, outputs zero; a late res_valid has no effect; a fresh run completes correctly.
REQ-033 SHALL: with ECC_ABORT_EN defined, estart dropped in DBL_WAIT -> IDLE after res_valid, no edone, previous Pox retained.

Source files
------------

// File: rtl/ecc_pmul_responder.sv
// Double-and-add scalar multiplication sequencer driving an external GF point-op unit.
// Optional abort support is compiled in with the ECC_ABORT_EN macro.
module ecc_pmul_responder (
    input  logic         clk,
    input  logic         rst,
    input  logic         estart,
    input  logic [162:0] k,
    input  logic [163:0] Px,
    input  logic [163:0] Py,
    output logic         op_valid,
    output logic         op_code,
    output logic [163:0] op_ax,
    output logic [163:0] op_ay,
    output logic [163:0] op_bx,
    output logic [163:0] op_by,
    input  logic         op_ready,
    input  logic         res_valid,
    input  logic [163:0] res_x,
    input  logic [163:0] res_y,
    output logic [163:0] Pox,
    output logic [163:0] Poy,
    output logic         Pinf,
    output logic         edone,
    output logic         busy
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_DBL_REQ,
        S_DBL_WAIT,
        S_ADD_CHK,
        S_ADD_REQ,
        S_ADD_WAIT,
        S_DONE,
        S_HOLD
    } state_t;

    localparam logic OP_DOUBLE = 1'b0;
    localparam logic OP_ADD    = 1'b1;

    state_t         state_q;
    logic [162:0]   k_q;
    logic [163:0]   px_q;
    logic [163:0]   py_q;
    logic [163:0]   acc_x_q;
    logic [163:0]   acc_y_q;
    logic           acc_inf_q;
    logic [7:0]     idx_q;

    logic           op_valid_q;
    logic           op_code_q;
    logic [163:0]   op_ax_q;
    logic [163:0]   op_ay_q;
    logic [163:0]   op_bx_q;
    logic [163:0]   op_by_q;
    logic [163:0]   pox_q;
    logic [163:0]   poy_q;
    logic           pinf_q;
    logic           edone_q;

    logic           k_bit_d;
    logic [163:0]   chk_x_d;
    logic [163:0]   chk_y_d;
    logic           chk_inf_d;
    logic           abort_now;
    logic           abort_wait;

`ifdef ECC_ABORT_EN
    // Remembers an estart drop seen while a GF op is in flight; honoured at res_valid.
    logic           abort_q;

    assign abort_now  = ~estart;
    assign abort_wait = abort_q | ~estart;

    always_ff @(posedge clk) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else if (state_q == S_LOAD) begin
            abort_q <= 1'b0;
        end else if ((state_q == S_DBL_WAIT || state_q == S_ADD_WAIT) && !estart) begin
            abort_q <= 1'b1;
        end
    end
`else
    assign abort_now  = 1'b0;
    assign abort_wait = 1'b0;
`endif

    // Accumulator value after an op-free ADD_CHK: either unchanged or loaded with P.
    always_comb begin
        k_bit_d   = k_q[idx_q];
        chk_inf_d = acc_inf_q & ~k_bit_d;
        chk_x_d   = acc_x_q;
        chk_y_d   = acc_y_q;
        if (k_bit_d && acc_inf_q) begin
            chk_x_d = px_q;
            chk_y_d = py_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            acc_inf_q  <= 1'b1;
            idx_q      <= '0;
            op_valid_q <= 1'b0;
            op_code_q  <= 1'b0;
            op_ax_q    <= '0;
            op_ay_q    <= '0;
            op_bx_q    <= '0;
            op_by_q    <= '0;
            pox_q      <= '0;
            poy_q      <= '0;
            pinf_q     <= 1'b0;
            edone_q    <= 1'b0;
        end else begin
            edone_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (estart) begin
                        state_q <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    k_q       <= k;
                    px_q      <= Px;
                    py_q      <= Py;
                    acc_x_q   <= '0;
                    acc_y_q   <= '0;
                    acc_inf_q <= 1'b1;
                    idx_q     <= 8'd162;
                    state_q   <= S_STEP;
                end

                S_STEP: begin
                    if (abort_now) begin
                        state_q <= S_IDLE;
                    end else if (acc_inf_q) begin
                        state_q <= S_ADD_CHK;
                    end else begin
                        op_valid_q <= 1'b1;
                        op_code_q  <= OP_DOUBLE;
                        op_ax_q    <= acc_x_q;
                        op_ay_q    <= acc_y_q;
                        op_bx_q    <= px_q;
                        op_by_q    <= py_q;
                        state_q    <= S_DBL_REQ;
                    end
                end

                S_DBL_REQ, S_ADD_REQ: begin
                    if (abort_now) begin
                        op_valid_q <= 1'b0;
                        state_q    <= S_IDLE;
                    end else if (op_ready) begin
                        op_valid_q <= 1'b0;
                        state_q    <= (state_q == S_DBL_REQ) ? S_DBL_WAIT : S_ADD_WAIT;
                    end
                end

                S_DBL_WAIT: begin
                    if (res_valid) begin
                        if (abort_wait) begin
                            state_q <= S_IDLE;
                        end else begin
                            acc_x_q <= res_x;
                            acc_y_q <= res_y;
                            state_q <= S_ADD_CHK;
                        end
                    end
                end

                S_ADD_CHK: begin
                    if (abort_now) begin
                        state_q <= S_IDLE;
                    end else if (k_bit_d && !acc_inf_q) begin
                        op_valid_q <= 1'b1;
                        op_code_q  <= OP_ADD;
                        op_ax_q    <= acc_x_q;
                        op_ay_q    <= acc_y_q;
                        op_bx_q    <= px_q;
                        op_by_q    <= py_q;
                        state_q    <= S_ADD_REQ;
                    end else begin
                        acc_x_q   <= chk_x_d;
                        acc_y_q   <= chk_y_d;
                        acc_inf_q <= chk_inf_d;
                        if (idx_q == 8'd0) begin
                            // Result registers load on entry so edone coincides with valid data.
                            pox_q   <= chk_inf_d ? '0 : chk_x_d;
                            poy_q   <= chk_inf_d ? '0 : chk_y_d;
                            pinf_q  <= chk_inf_d;
                            edone_q <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q   <= idx_q - 8'd1;
                            state_q <= S_STEP;
                        end
                    end
                end

                S_ADD_WAIT: begin
                    if (res_valid) begin
                        if (abort_wait) begin
                            state_q <= S_IDLE;
                        end else begin
                            acc_x_q   <= res_x;
                            acc_y_q   <= res_y;
                            acc_inf_q <= 1'b0;
                            if (idx_q == 8'd0) begin
                                pox_q   <= res_x;
                                poy_q   <= res_y;
                                pinf_q  <= 1'b0;
                                edone_q <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                idx_q   <= idx_q - 8'd1;
                                state_q <= S_STEP;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_q <= S_HOLD;
                end

                S_HOLD: begin
                    if (!estart) begin
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign op_valid = op_valid_q;
    assign op_code  = op_code_q;
    assign op_ax    = op_ax_q;
    assign op_ay    = op_ay_q;
    assign op_bx    = op_bx_q;
    assign op_by    = op_by_q;
    assign Pox      = pox_q;
    assign Poy      = poy_q;
    assign Pinf     = pinf_q;
    assign edone    = edone_q;
    assign busy     = (state_q != S_IDLE);

endmodule
